// File: rtl/led_adder_seq.sv
// led_adder_seq: switch-driven sequencer for the 2-bit LED adder.
// Debounces four switches, steps through operand entry (A, then B), strobes
// the operands to an external combinational adder, captures the 3-bit sum
// and shows it on the LEDs with a blinking LED_4.
// Optional build macro LAMP_TEST_EN: adds a power-on lamp test state that
// lights all LEDs for SHOW_CYCLES cycles after reset release.
module led_adder_seq #(
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int SHOW_CYCLES    = 25000000,
  parameter int BLINK_HALF     = 6250000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Switch_1,
  input  logic       i_Switch_2,
  input  logic       i_Switch_3,
  input  logic       i_Switch_4,
  output logic [1:0] o_Op_A,
  output logic [1:0] o_Op_B,
  output logic       o_Add_Valid,
  input  logic [2:0] i_Sum,
  output logic       o_LED_1,
  output logic       o_LED_2,
  output logic       o_LED_3,
  output logic       o_LED_4
);

  localparam int DB_W = $clog2(DEBOUNCE_LIMIT + 1);
  localparam int SH_W = $clog2(SHOW_CYCLES + 1);
  localparam int BL_W = $clog2(BLINK_HALF + 1);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [SH_W-1:0] SH_LAST = SH_W'(SHOW_CYCLES - 1);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_HALF - 1);

  typedef enum logic [2:0] {
    ENTER_A,
    ENTER_B,
    CALC,
    CAPTURE,
    SHOW
`ifdef LAMP_TEST_EN
    , LAMP
`endif
  } state_t;

`ifdef LAMP_TEST_EN
  localparam state_t RESET_STATE = LAMP;
`else
  localparam state_t RESET_STATE = ENTER_A;
`endif

  // Switch index: 0 = sw1 (inc), 1 = sw2 (advance), 2 = sw3 (back), 3 = sw4 (clear)
  logic [3:0]      sw_raw;
  logic [3:0]      sync1;
  logic [3:0]      sync2;
  logic [3:0]      stable;
  logic [3:0]      press;
  logic [DB_W-1:0] db_cnt [4];

  state_t          state;
  logic [1:0]      a;
  logic [1:0]      b;
  logic [2:0]      result;
  logic [SH_W-1:0] show_cnt;
  logic [BL_W-1:0] blink_cnt;
  logic            blink;
  logic            add_valid;
  logic [3:0]      led;          // {LED_1, LED_2, LED_3, LED_4}

  assign sw_raw      = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};
  assign o_Op_A      = a;
  assign o_Op_B      = b;
  assign o_Add_Valid = add_valid;
  assign o_LED_1     = led[3];
  assign o_LED_2     = led[2];
  assign o_LED_3     = led[1];
  assign o_LED_4     = led[0];

  // Two-flop synchronisers, per-switch debounce counters and rising-edge press pulses
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      press  <= '0;
      for (int unsigned i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= sw_raw;
      sync2 <= sync1;
      for (int unsigned i = 0; i < 4; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= sync2[i];
          db_cnt[i] <= '0;
          // pulse only when the accepted level is a press, not a release
          press[i]  <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Operand-entry / add / display sequencer with registered LED and valid outputs
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state     <= RESET_STATE;
      a         <= '0;
      b         <= '0;
      result    <= '0;
      show_cnt  <= '0;
      blink_cnt <= '0;
      blink     <= 1'b0;
      add_valid <= 1'b0;
      led       <= '0;
    end else begin
      add_valid <= 1'b0;

      // LEDs follow the state held during this cycle, so they lag it by one clock
      case (state)
        ENTER_A: led <= {a, 2'b10};
        ENTER_B: led <= {b, 2'b01};
        SHOW:    led <= {result, blink};
`ifdef LAMP_TEST_EN
        LAMP:    led <= '1;
`endif
        default: led <= led;
      endcase

      if (press[3]) begin
        a      <= '0;
        b      <= '0;
        result <= '0;
        state  <= ENTER_A;
      end else begin
        case (state)
          ENTER_A: begin
            // sw3 outranks sw1, so a simultaneous sw3 swallows the increment
            if (press[1])                  state <= ENTER_B;
            else if (press[0] && !press[2]) a    <= a + 2'd1;
          end
          ENTER_B: begin
            if (press[1]) begin
              state     <= CALC;
              add_valid <= 1'b1;
            end else if (press[2]) begin
              state <= ENTER_A;
            end else if (press[0]) begin
              b <= b + 2'd1;
            end
          end
          CALC: state <= CAPTURE;
          CAPTURE: begin
            result    <= i_Sum;
            state     <= SHOW;
            show_cnt  <= '0;
            blink_cnt <= '0;
            blink     <= 1'b1;
          end
          SHOW: begin
            if (press[1] || show_cnt == SH_LAST) begin
              state <= ENTER_A;
            end else begin
              show_cnt <= show_cnt + SH_W'(1);
            end
            if (blink_cnt == BL_LAST) begin
              blink_cnt <= '0;
              blink     <= ~blink;
            end else begin
              blink_cnt <= blink_cnt + BL_W'(1);
            end
          end
`ifdef LAMP_TEST_EN
          LAMP: begin
            if (show_cnt == SH_LAST) begin
              state    <= ENTER_A;
              show_cnt <= '0;
            end else begin
              show_cnt <= show_cnt + SH_W'(1);
            end
          end
`endif
          default: state <= ENTER_A;
        endcase
      end
    end
  end

endmodule
